// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle count-based shift/rotate driver
// stepping a combinational single-bit ALU once per clock.
module shift_sequencer #(
  parameter int WIDTH      = 16,
  parameter bit MASK_COUNT = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data,
  input  logic [7:0]       count,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_r,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cf,
  output logic             cf_valid
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [7:0]       cnt;
  logic [1:0]       op_q;
  logic [7:0]       cnt_init;
  logic             cf_next;

  assign cnt_init = MASK_COUNT ? {3'b000, count[4:0]}
                               : count;

  assign alu_a = work;
  assign alu_b = '0;

  // op bit 0 selects a right-moving op, so the outgoing bit is the LSB
  assign cf_next = op_q[0] ? work[0] : work[WIDTH-1];

  // Map the latched op onto the ALU opcode space
  always_comb begin
    alu_op = 4'd2;
    unique case (op_q)
      2'd0: alu_op = 4'd2;
      2'd1: alu_op = 4'd3;
      2'd2: alu_op = 4'd4;
      2'd3: alu_op = 4'd5;
      default: alu_op = 4'd2;
    endcase
  end

  // Sequencer FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      work     <= '0;
      cnt      <= '0;
      op_q     <= '0;
      result   <= '0;
      cf       <= 1'b0;
      cf_valid <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done     <= 1'b0;
      cf_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            work <= data;
            cnt  <= cnt_init;
            busy <= 1'b1;
            if (cnt_init == 8'd0) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= data;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          work <= alu_r;
          cf   <= cf_next;
          cnt  <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            state    <= DONE;
            done     <= 1'b1;
            cf_valid <= 1'b1;
            result   <= alu_r;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed bench for shift_sequencer
// with a behavioural single-step ALU in the loop.
module tb_shift_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] data;
  logic [7:0]  count;
  logic [3:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_r;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cf;
  logic        cf_valid;

  int n_pass;
  int n_total;
  int ndone;
  int cyc;

  shift_sequencer #(
    .WIDTH(16),
    .MASK_COUNT(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .op(op),
    .data(data),
    .count(count),
    .alu_op(alu_op),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_r(alu_r),
    .busy(busy),
    .done(done),
    .result(result),
    .cf(cf),
    .cf_valid(cf_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference single-step ALU
  always_comb begin
    alu_r = alu_a;
    case (alu_op)
      4'd2: alu_r = {alu_a[14:0], 1'b0};
      4'd3: alu_r = {1'b0, alu_a[15:1]};
      4'd4: alu_r = {alu_a[14:0], alu_a[15]};
      4'd5: alu_r = {alu_a[0], alu_a[15:1]};
      default: alu_r = alu_a;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic do_op(input string tag,
                       input logic [1:0] o,
                       input logic [15:0] d,
                       input logic [7:0] c,
                       input int exp_cyc,
                       input logic [15:0] exp_res,
                       input logic exp_cf,
                       input logic exp_cfv,
                       input logic [3:0] exp_aop);
    op = o;
    data = d;
    count = c;
    start = 1'b1;
    step();
    start = 1'b0;
    op = ~o;
    data = ~d;
    count = 8'h00;
    cyc = 1;
    chk({tag, "_busy1"}, 32'(busy), 32'd1);
    chk({tag, "_aop"}, 32'(alu_op), 32'(exp_aop));
    while (done !== 1'b1 && cyc < 300) begin
      step();
      cyc++;
      if (done !== 1'b1 && busy === 1'b1)
        chk({tag, "_aop_run"}, 32'(alu_op),
            32'(exp_aop));
    end
    chk({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_res"}, 32'(result), 32'(exp_res));
    chk({tag, "_cf"}, 32'(cf), 32'(exp_cf));
    chk({tag, "_cfv"}, 32'(cf_valid), 32'(exp_cfv));
    step();
    chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    chk({tag, "_hold"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset_n = 1'b0;
    start = 1'b0;
    op = 2'd0;
    data = 16'h0;
    count = 8'h0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", 32'(result), 32'd0);
    chk("rst_cf", {30'd0, cf, cf_valid}, 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    reset_n = 1'b1;
    step();

    do_op("shl1", 2'd0, 16'h8001, 8'd1,
          2, 16'h0002, 1'b1, 1'b1, 4'd2);
    do_op("ror4", 2'd3, 16'h0001, 8'd4,
          5, 16'h1000, 1'b0, 1'b1, 4'd5);
    do_op("rol17", 2'd2, 16'h8000, 8'd17,
          18, 16'h0001, 1'b1, 1'b1, 4'd4);
    do_op("cnt0", 2'd1, 16'h1234, 8'd0,
          1, 16'h1234, 1'b1, 1'b0, 4'd3);
    do_op("shr21", 2'd1, 16'hF000, 8'h21,
          2, 16'h7800, 1'b0, 1'b1, 4'd3);
    do_op("shl17", 2'd0, 16'hFFFF, 8'd17,
          18, 16'h0000, 1'b0, 1'b1, 4'd2);
    do_op("ror20m", 2'd3, 16'h00C1, 8'h20,
          1, 16'h00C1, 1'b0, 1'b0, 4'd5);

    // start held high through a SHL by 3
    op = 2'd0;
    data = 16'h0123;
    count = 8'd3;
    start = 1'b1;
    step();
    data = 16'hFFFF;
    count = 8'd7;
    op = 2'd3;
    ndone = 0;
    for (int i = 1; i <= 4; i++) begin
      if (done === 1'b1) ndone++;
      if (i == 4) begin
        chk("hold_done4", 32'(done), 32'd1);
        chk("hold_res", 32'(result), 32'h0918);
      end
      step();
    end
    chk("hold_c5", {30'd0, busy, done}, 32'd0);
    chk("hold_ndone", 32'(ndone), 32'd1);
    op = 2'd1;
    data = 16'h0100;
    count = 8'd1;
    step();
    start = 1'b0;
    chk("reacc_busy", 32'(busy), 32'd1);
    step();
    chk("reacc_done", 32'(done), 32'd1);
    chk("reacc_res", 32'(result), 32'h0080);
    step();

    // reset in cycle 2 of a ROL by 5
    op = 2'd2;
    data = 16'h1357;
    count = 8'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_res", 32'(result), 32'd0);
    chk("abort_cf", 32'(cf), 32'd0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) ndone++;
      step();
    end
    chk("abort_nodone", 32'(ndone), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle driver for the single-bit shift/rotate operations of the combinational 16-bit ALU.
- Implements count-based shifts and rotates (shift by immediate or CL): applies one ALU step per clock, count times.
- Sits directly upstream of the ALU. It drives the ALU's alu_op, A and B inputs and feeds the ALU's R output back into its working register.
- Also produces the last bit shifted out, which the flags logic uses as carry.

Parameters:
- WIDTH, 16, operand and result width; must match the ALU.
- MASK_COUNT, 1, when 1 the count is masked to its low 5 bits; when 0 the full 8-bit count is used.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  2  0=SHL, 1=SHR, 2=ROL, 3=ROR.
- data  in  WIDTH  operand to shift.
- count  in  8  shift count (CL or immediate).
- alu_op  out  4  to ALU: SHL=2, SHR=3, ROL=4, ROR=5.
- alu_a  out  WIDTH  to ALU A: working register.
- alu_b  out  WIDTH  to ALU B: constant 0.
- alu_r  in  WIDTH  from ALU R: one-step result of alu_a.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse when result is final.
- result  out  WIDTH  final value; held until the next accepted start.
- cf  out  1  last bit shifted or rotated out.
- cf_valid  out  1  high with done if at least one step was executed.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE; the working register, remaining count, latched op, result, cf, cf_valid, done and busy all go to 0.
  - Reset in RUN or DONE aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1, latch op, work=data, and cnt=(MASK_COUNT ? count[4:0] : count).
  - cnt==0 goes to DONE; otherwise goes to RUN.
  - start=0 stays in IDLE.
- RUN, every cycle:
  - cf_next = work[WIDTH-1] for SHL/ROL, work[0] for SHR/ROR.
  - work <= alu_r; cf <= cf_next; cnt <= cnt-1.
  - If cnt==1 at that edge, go to DONE; otherwise stay in RUN.
- DONE:
  - done=1 for exactly this cycle; result=work; go to IDLE next edge.
  - cf_valid=1 if at least one RUN cycle executed in this operation; 0 for count 0.
  - cf is unchanged for count 0.
- Combinational outputs:
  - alu_a=work always; alu_b=0 always.
  - alu_op is the mapping of the latched op, driven in every state.
  - The ALU is purely combinational, so alu_r is valid in the same cycle.
- Latency: start sampled at edge 0. With N = masked count:
  - N>0: done is high in cycle N+1.
  - N=0: done is high in cycle 1.
- Handshake:
  - start while busy=1 is ignored; it is neither queued nor able to corrupt the operation.
  - start in the same cycle as done is ignored; the earliest new accept is the cycle after done.
  - Inputs op, data and count are only sampled at accept and may change freely afterwards.
- Counts:
  - Rotate counts ≥ WIDTH are executed literally, step by step, with no modulo shortcut.
  - Shift counts ≥ WIDTH yield 0. cf is the last bit out; after WIDTH steps that is 0 unless it was refilled, which it is not.
  - MASK_COUNT=0 with count=255 takes 255 RUN cycles.
- result and cf hold their values through IDLE until the next operation completes.

Test Plan:
- SHL, data=16'h8001, count=1 -> done in cycle 2; result=16'h0002, cf=1, cf_valid=1; busy high for cycles 1-2.
- ROR, data=16'h0001, count=4 -> done in cycle 5; result=16'h1000, cf=0; alu_op=5 throughout RUN.
- ROL, data=16'h8000, count=17 -> done in cycle 18; result=16'h0001, cf=1.
- MASK_COUNT=1 with SHR, data=16'hF000, count=8'h21 (masks to 1) -> result=16'h7800, cf=0, done in cycle 2. Separately, count=0 -> done in cycle 1, result=data, cf_valid=0, cf unchanged.
- start re-asserted every cycle during a SHL with count=3 -> exactly one done, in cycle 4, result=data<<3. A new start in the cycle after done is accepted.
- reset_n=0 in cycle 2 of an ROL with count=5 -> next cycle state IDLE, busy=0, result=0, cf=0, and no done pulse ever appears.
